// File: rtl/dram_arbiter.sv
// Data-RAM arbiter: CPU has priority, a DMA requester is served on idle CPU cycles
// or by a one-cycle forced CPU stall after STARVE_MAX waiting cycles. Optional stats: DRAM_ARB_STATS_EN.
module dram_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic              cpu_re_i,
    input  logic              cpu_we_i,
    input  logic [7:0]        cpu_dat_i,
    output logic              cpu_stall_o,
    input  logic [ADDR_W-1:0] dma_adr_i,
    input  logic [7:0]        dma_dat_i,
    input  logic              dma_stb_i,
    input  logic              dma_we_i,
    output logic              dma_ack_o,
    output logic [7:0]        dma_dat_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dat_o,
`ifdef DRAM_ARB_STATS_EN
    output logic [15:0]       stat_grants_o,
    output logic [15:0]       stat_stalls_o,
`endif
    input  logic [7:0]        ram_dat_i
);
    // state     | meaning
    // S_IDLE    | a DMA grant may be issued this cycle
    // S_DMA_ACK | granted DMA access completes, CPU owns the RAM
    typedef enum logic {S_IDLE, S_DMA_ACK} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q;
    logic       ack_q;
    logic [3:0] starve_q, starve_d;
    logic       cpu_req, grant;

    assign cpu_req = cpu_re_i | cpu_we_i;
    assign grant   = ~rst_i & (state_q == S_IDLE) & dma_stb_i
                   & (~cpu_req | (starve_q == STARVE_LIM));

    always_comb begin
        starve_d = starve_q;
        if (grant || !dma_stb_i) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        state_q <= S_DMA_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                S_DMA_ACK: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Reset in the ack cycle aborts the access, so the ack is masked by rst_i.
    assign dma_ack_o   = ack_q & ~rst_i;
    assign dma_dat_o   = dma_ack_o ? ram_dat_i : 8'h00;
    assign cpu_stall_o = grant & cpu_req;
    assign ram_adr_o   = grant ? dma_adr_i : cpu_adr_i;
    assign ram_dat_o   = grant ? dma_dat_i : cpu_dat_i;
    assign ram_we_o    = ~rst_i & (grant ? dma_we_i : cpu_we_i);

`ifdef DRAM_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_stalls_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (grant)       stat_grants_q <= stat_grants_q + 16'd1;
            if (cpu_stall_o) stat_stalls_q <= stat_stalls_q + 16'd1;
        end
    end

    assign stat_grants_o = stat_grants_q;
    assign stat_stalls_o = stat_stalls_q;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: directed scenarios followed by random CPU/DMA traffic
// checked against a cycle-level reference model with its own memory image.
module tb_dram_arbiter;
    localparam int AW = 9;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] cpu_adr_i, dma_adr_i, ram_adr_o;
    logic          cpu_re_i, cpu_we_i, cpu_stall_o;
    logic [7:0]    cpu_dat_i, dma_dat_i, dma_dat_o, ram_dat_o, ram_dat_i;
    logic          dma_stb_i, dma_we_i, dma_ack_o, ram_we_o;
`ifdef DRAM_ARB_STATS_EN
    logic [15:0]   stat_grants_o, stat_stalls_o;
`endif

    dram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_adr_i(cpu_adr_i), .cpu_re_i(cpu_re_i), .cpu_we_i(cpu_we_i),
        .cpu_dat_i(cpu_dat_i), .cpu_stall_o(cpu_stall_o),
        .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i), .dma_stb_i(dma_stb_i),
        .dma_we_i(dma_we_i), .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o),
        .ram_adr_o(ram_adr_o), .ram_we_o(ram_we_o), .ram_dat_o(ram_dat_o),
`ifdef DRAM_ARB_STATS_EN
        .stat_grants_o(stat_grants_o), .stat_stalls_o(stat_stalls_o),
`endif
        .ram_dat_i(ram_dat_i)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous read, read-before-write.
    logic [7:0] ram_arr [512];
    always @(posedge clk) begin
        if (ram_we_o) ram_arr[ram_adr_o] <= ram_dat_o;
        ram_dat_i <= ram_arr[ram_adr_o];
    end

    int         checks = 0, failures = 0;
    int         m_ack = 0, m_cnt = 0, n_grants = 0, n_stalls = 0;
    logic [7:0] mem [512];
    int         dma_q[$];
    int         cpu_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then predict and check.
    task automatic cycle(input bit r, input bit cre, input bit cwe, input int cadr, input int cdat,
                         input bit stb, input bit dwe, input int dadr, input int ddat);
        bit creq, g;
        @(negedge clk);
        rst_i = r; cpu_re_i = cre; cpu_we_i = cwe; cpu_adr_i = AW'(cadr); cpu_dat_i = 8'(cdat);
        dma_stb_i = stb; dma_we_i = dwe; dma_adr_i = AW'(dadr); dma_dat_i = 8'(ddat);
        #1;
        creq = cre | cwe;
        g = 1'b0;
        if (r) begin
            chk("rst_stall", cpu_stall_o, 0);
            chk("rst_ram_we", ram_we_o, 0);
            chk("rst_ack", dma_ack_o, 0);
            m_ack = 0; m_cnt = 0; n_grants = 0; n_stalls = 0;
            dma_q.delete();
        end else begin
            g = (m_ack == 0) && stb && (!creq || m_cnt == SM);
            chk("stall", cpu_stall_o, int'(g && creq));
            chk("ack", dma_ack_o, m_ack);
            chk("ram_we", ram_we_o, g ? int'(dwe) : int'(cwe));
            if (g || creq) chk("ram_adr", ram_adr_o, g ? dadr : cadr);
            if (g) begin
                dma_q.push_back(dwe ? -1 : int'(mem[dadr]));
                if (dwe) mem[dadr] = 8'(ddat);
                n_grants++;
                if (creq) n_stalls++;
            end else begin
                if (cre) cpu_q.push_back(int'(mem[cadr]));
                if (cwe) mem[cadr] = 8'(cdat);
            end
            m_cnt = (g || !stb) ? 0 : ((m_cnt < SM) ? m_cnt + 1 : SM);
            m_ack = g ? 1 : 0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents DMA or CPU read data.
    bit rd_prev = 1'b0;
    initial forever begin
        int e;
        @(negedge clk);
        #2;
        if (dma_ack_o) begin
            if (dma_q.size() == 0) chk("dma_ack_unexpected", 1, 0);
            else begin
                e = dma_q.pop_front();
                if (e >= 0) chk("dma_rdata", dma_dat_o, e);
            end
        end
        if (rd_prev) begin
            if (cpu_q.size() == 0) chk("cpu_rd_unexpected", 1, 0);
            else chk("cpu_rdata", ram_dat_i, cpu_q.pop_front());
        end
        rd_prev = cpu_re_i && !cpu_stall_o && !rst_i;
    end

    initial begin
        bit pend, dwe, cre, cwe, stalled, r;
        int dadr, ddat, cadr, cdat, waitc, k;
        for (int i = 0; i < 512; i++) begin
            ram_arr[i] = 8'h00;
            mem[i] = 8'h00;
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // idle CPU: DMA write 0x5A @0x010, then read it back
        cycle(0, 0, 0, 0, 0, 1, 1, 'h010, 'h5A);
        cycle(0, 0, 0, 0, 0, 1, 1, 'h010, 'h5A);
        cycle(0, 0, 0, 0, 0, 1, 0, 'h010, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 'h010, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // CPU busy every cycle: forced grant on the 5th cycle
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 'h030 + i, 0, 1, 0, 'h010, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // CPU read 0x020 (0x33) wins, DMA served the following cycle
        cycle(0, 0, 1, 'h020, 'h33, 0, 0, 0, 0);
        cycle(0, 1, 0, 'h020, 0, 1, 0, 'h010, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 'h010, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 'h010, 0);
        // reset during DMA_ACK, then retry
        cycle(0, 0, 0, 0, 0, 1, 0, 'h020, 0);
        cycle(1, 0, 0, 0, 0, 1, 0, 'h020, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 'h020, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 'h020, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        pend = 0; stalled = 0; waitc = 0;
        dwe = 0; dadr = 0; ddat = 0; cre = 0; cwe = 0; cadr = 0; cdat = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) == 0);
            if (!stalled) begin
                k = $urandom_range(0, 9);
                if (((i / 200) % 2) == 1) begin
                    cre = (k < 5); cwe = !cre;
                end else begin
                    cre = (k < 4); cwe = (k >= 4 && k < 7);
                end
                cadr = $urandom_range(0, 15); cdat = $urandom_range(0, 255);
            end
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1; waitc = 0;
                dwe = $urandom_range(0, 1); dadr = $urandom_range(0, 15); ddat = $urandom_range(0, 255);
            end else if (pend && $urandom_range(0, 59) == 0) begin
                pend = 0;
            end
            cycle(r, cre, cwe, cadr, cdat, pend, dwe, dadr, ddat);
            stalled = cpu_stall_o;
            if (dma_ack_o) pend = 0;
            else if (pend) begin
                waitc++;
                if (waitc > 40) begin
                    chk("dma_timeout", waitc, 0);
                    pend = 0;
                end
            end
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dma_q_drained", dma_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);
`ifdef DRAM_ARB_STATS_EN
        chk("stat_grants", stat_grants_o, n_grants % 65536);
        chk("stat_stalls", stat_stalls_o, n_stalls % 65536);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
